// File: rtl/sensor_readout_controller_if.sv
// sensor_readout_controller_if: valid/ready pixel beat stream toward the frame sink
interface sensor_readout_controller_if #(
    parameter int DATA_W = 16
) ();
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] data_out;
    logic              out_last_in_row;
    logic              out_first_of_frame;
    modport master (output out_valid, data_out, out_last_in_row, out_first_of_frame, input out_ready);
    modport slave  (input out_valid, data_out, out_last_in_row, out_first_of_frame, output out_ready);
endinterface

// File: rtl/sensor_readout_controller.sv
// sensor_readout_controller: erase/expose/ramp/readout frame sequencer with a backpressured row-buffer drain
module sensor_readout_controller #(
    parameter int PIXEL_ARRAY_HEIGHT = 4,
    parameter int PIXEL_ARRAY_WIDTH  = 8,
    parameter int PIXEL_BITS         = 8,
    parameter int OUTPUT_BUS_WIDTH   = 2,
    parameter int ERASE_CYCLES       = 5
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    input  logic                                    continuous,
    input  logic [15:0]                             expose_len,
    output logic                                    pixel_erase,
    output logic                                    pixel_expose,
    output logic                                    analog_ramp,
    output logic [PIXEL_BITS-1:0]                   digital_ramp,
    output logic [PIXEL_ARRAY_HEIGHT-1:0]           row_select,
    input  logic [PIXEL_ARRAY_WIDTH*PIXEL_BITS-1:0] pixel_data,
    sensor_readout_controller_if.master             out_bus,
    output logic                                    frame_finished,
    output logic                                    busy
);
    localparam int NB   = PIXEL_ARRAY_WIDTH / OUTPUT_BUS_WIDTH;
    localparam int BW   = OUTPUT_BUS_WIDTH * PIXEL_BITS;
    localparam int RW   = PIXEL_ARRAY_HEIGHT > 1 ? $clog2(PIXEL_ARRAY_HEIGHT) : 1;
    localparam int CW   = NB > 1 ? $clog2(NB) : 1;
    localparam int RAMP = 1 << PIXEL_BITS;

    typedef enum logic [2:0] {IDLE, ERASE, EXPOSE, CONVERT, SEL_A, SEL_B, DRAIN, DONE} state_t;

    state_t               state, nxt;
    logic [31:0]          cnt;
    logic [15:0]          exp_len;
    logic [RW-1:0]        row;
    logic [CW-1:0]        beat;
    logic [NB-1:0][BW-1:0] row_buf;
    logic                 fire, last_beat, last_row, relatch;

    assign fire      = out_bus.out_valid && out_bus.out_ready;
    assign last_beat = beat == CW'(NB - 1);
    assign last_row  = row == RW'(PIXEL_ARRAY_HEIGHT - 1);
    assign relatch   = (state == IDLE && start) || (state == DONE && continuous);

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start) nxt = ERASE;
            ERASE:   if (cnt == 32'(ERASE_CYCLES - 1)) nxt = EXPOSE;
            EXPOSE:  if (cnt == 32'(exp_len) - 32'd1) nxt = CONVERT;
            CONVERT: if (cnt == 32'(RAMP - 1)) nxt = SEL_A;
            SEL_A:   nxt = SEL_B;
            SEL_B:   nxt = DRAIN;
            DRAIN:   if (fire && last_beat) nxt = last_row ? DONE : SEL_A;
            DONE:    nxt = continuous ? ERASE : IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        pixel_erase                = state == ERASE;
        pixel_expose               = state == EXPOSE;
        analog_ramp                = state == CONVERT;
        digital_ramp               = state == CONVERT ? cnt[PIXEL_BITS-1:0] : '0;
        row_select                 = (state == SEL_A || state == SEL_B) ? PIXEL_ARRAY_HEIGHT'(1) << row : '0;
        out_bus.out_valid          = state == DRAIN;
        out_bus.data_out           = state == DRAIN ? row_buf[beat] : '0;
        out_bus.out_last_in_row    = state == DRAIN && last_beat;
        out_bus.out_first_of_frame = state == DRAIN && row == '0 && beat == '0;
        frame_finished             = state == DONE;
        busy                       = state != IDLE;
    end

    // cnt restarts on every state change so each timed phase counts from 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            exp_len <= '0;
            row     <= '0;
            beat    <= '0;
            row_buf <= '0;
        end else begin
            state <= nxt;
            cnt   <= nxt != state ? '0 : cnt + 32'd1;
            if (relatch) exp_len <= expose_len == 16'd0 ? 16'd1 : expose_len;
            if (state == SEL_B) row_buf <= pixel_data;
            if (fire) begin
                beat <= last_beat ? '0 : beat + 1'b1;
                if (last_beat) row <= last_row ? '0 : row + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sensor_readout_controller.sv
// tb_sensor_readout_controller: randomized frames with a beat scoreboard and a cycle-timing reference model
module tb_sensor_readout_controller;
    localparam int H  = 4;
    localparam int W  = 8;
    localparam int PB = 8;
    localparam int OBW = 2;
    localparam int E  = 5;
    localparam int NB = W / OBW;
    localparam int BW = OBW * PB;
    localparam int R  = 1 << PB;
    localparam int VW = 6 + PB + H;

    typedef struct packed {
        logic [BW-1:0] d;
        logic          l;
        logic          f;
    } beat_t;

    logic              clk, rst, start, continuous;
    logic [15:0]       expose_len;
    logic              pixel_erase, pixel_expose, analog_ramp, frame_finished, busy;
    logic [PB-1:0]     digital_ramp;
    logic [H-1:0]      row_select;
    logic [W*PB-1:0]   pixel_data;
    logic [PB-1:0]     pix [H][W];
    beat_t             exp_q[$];
    int                checks = 0, passed = 0, ff_seen = 0, ff_exp = 0, exp_cycles = 0, ready_mode = 0;

    sensor_readout_controller_if #(.DATA_W(BW)) out_bus ();

    sensor_readout_controller #(
        .PIXEL_ARRAY_HEIGHT(H), .PIXEL_ARRAY_WIDTH(W), .PIXEL_BITS(PB),
        .OUTPUT_BUS_WIDTH(OBW), .ERASE_CYCLES(E)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .continuous(continuous), .expose_len(expose_len),
        .pixel_erase(pixel_erase), .pixel_expose(pixel_expose), .analog_ramp(analog_ramp),
        .digital_ramp(digital_ramp), .row_select(row_select), .pixel_data(pixel_data),
        .out_bus(out_bus), .frame_finished(frame_finished), .busy(busy)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // pixel array model: selected row drives the data bus
    always_comb begin
        pixel_data = '0;
        for (int r = 0; r < H; r++)
            if (row_select[r])
                for (int c = 0; c < W; c++) pixel_data[c*PB +: PB] = pix[r][c];
    end

    task automatic chk(input string name, input logic ok, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, want);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({pixel_erase, pixel_expose, analog_ramp, digital_ramp, row_select, out_bus.out_valid,
                    out_bus.data_out, out_bus.out_last_in_row, out_bus.out_first_of_frame, frame_finished, busy});
    endfunction

    // expected control outputs for cycle k of a frame with full-rate sink, from the timing rules
    function automatic logic [VW-1:0] exp_vec(input int k, input int x);
        int t, r, p;
        logic e, ex, ra, v, ff, b;
        logic [PB-1:0] dr;
        logic [H-1:0] rs;
        e  = k >= 1 && k <= E;
        ex = k > E && k <= E + x;
        ra = k > E + x && k <= E + x + R;
        dr = ra ? PB'(k - E - x - 1) : '0;
        t  = k - (E + x + R + 1);
        rs = '0; v = 0; ff = 0;
        if (t >= 0) begin
            r = t / (2 + NB);
            p = t % (2 + NB);
            if (r < H) begin
                if (p < 2) rs = H'(1 << r);
                else v = 1;
            end else if (t == H * (2 + NB)) ff = 1;
        end
        b = k >= 1 && k <= E + x + R + H * (2 + NB) + 1;
        return {e, ex, ra, dr, rs, v, ff, b};
    endfunction

    task automatic load_frame(input bit pat, input int copies);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) pix[r][c] = pat ? PB'(16 * r + c) : PB'($urandom);
        repeat (copies)
            for (int r = 0; r < H; r++)
                for (int j = 0; j < NB; j++) begin
                    beat_t b;
                    b.d = '0;
                    for (int k = 0; k < OBW; k++) b.d[k*PB +: PB] = pix[r][j*OBW+k];
                    b.l = j == NB - 1;
                    b.f = r == 0 && j == 0;
                    exp_q.push_back(b);
                end
    endtask

    task automatic start_frame(input logic [15:0] len);
        @(posedge clk); #1;
        expose_len = len;
        start = 1;
        @(posedge clk); #1;
        start = 0;
    endtask

    task automatic wait_finish(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_finished && n < 3000);
        chk({name, " finished"}, frame_finished, 64'(frame_finished), 64'd1);
        chk({name, " queue drained"}, exp_q.size() == 0, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        out_bus.out_ready = 1;
        forever begin
            @(posedge clk); #1;
            out_bus.out_ready = ready_mode == 2 ? 1'($urandom_range(0, 1)) : ready_mode == 0;
        end
    end

    // scoreboard monitor: compares every accepted beat, and holds on stalled beats
    initial begin
        beat_t prev, got, want;
        logic held;
        held = 0;
        prev = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 0;
                continue;
            end
            got = {out_bus.data_out, out_bus.out_last_in_row, out_bus.out_first_of_frame};
            if (out_bus.out_valid) begin
                if (held) chk("stalled beat stable", got == prev, 64'(got), 64'(prev));
                chk("row_select idle while draining", row_select == '0, 64'(row_select), 64'd0);
                if (out_bus.out_ready) begin
                    if (exp_q.size() == 0) chk("unexpected beat", 1'b0, 64'(got), 64'd0);
                    else begin
                        want = exp_q.pop_front();
                        chk("beat", got == want, 64'(got), 64'(want));
                    end
                end
            end
            held = out_bus.out_valid && !out_bus.out_ready;
            prev = got;
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst && frame_finished) ff_seen++;
        if (!rst && pixel_expose) exp_cycles++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, bz, len;
        rst = 1; start = 0; continuous = 0; expose_len = 16'd10;
        repeat (2) @(negedge clk);
        chk("outputs in reset", all_outs() == 0, all_outs(), 64'd0);
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("outputs after reset", all_outs() == 0, all_outs(), 64'd0);

        // frame 1: exact cycle timing with row data 16r+c
        load_frame(1, 1);
        start_frame(16'd10);
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            chk($sformatf("timing cycle %0d", k),
                {pixel_erase, pixel_expose, analog_ramp, digital_ramp, row_select, out_bus.out_valid, frame_finished, busy} == exp_vec(k, 10),
                64'({pixel_erase, pixel_expose, analog_ramp, digital_ramp, row_select, out_bus.out_valid, frame_finished, busy}),
                64'(exp_vec(k, 10)));
        end
        chk("frame 1 queue drained", exp_q.size() == 0, 64'(exp_q.size()), 64'd0);
        ff_exp++;

        // frame 2: sink stalls for 20 cycles from the first beat
        ready_mode = 1;
        load_frame(0, 1);
        start_frame(16'($urandom_range(1, 30)));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_bus.out_valid && n < 1000);
        chk("first beat appears", out_bus.out_valid, 64'(out_bus.out_valid), 64'd1);
        repeat (20) begin
            @(negedge clk);
            chk("backpressure hold", out_bus.out_valid && row_select == '0, 64'({out_bus.out_valid, row_select}), 64'({1'b1, H'(0)}));
        end
        ready_mode = 0;
        wait_finish("backpressure frame");
        ff_exp++;

        // frame 3: random sink readiness and random exposure
        ready_mode = 2;
        len = $urandom_range(0, 20);
        load_frame(0, 1);
        @(posedge clk); #1 exp_cycles = 0;
        start_frame(16'(len));
        wait_finish("random ready frame");
        chk("exposure length", exp_cycles == (len == 0 ? 1 : len), 64'(exp_cycles), 64'(len == 0 ? 1 : len));
        ff_exp++;

        // frame 4: zero exposure and a START during conversion
        ready_mode = 0;
        load_frame(0, 1);
        @(posedge clk); #1 exp_cycles = 0;
        start_frame(16'd0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!analog_ramp && n < 1000);
        chk("ramp reached", analog_ramp, 64'(analog_ramp), 64'd1);
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        wait_finish("zero exposure frame");
        chk("zero exposure is one cycle", exp_cycles == 1, 64'(exp_cycles), 64'd1);
        ff_exp++;
        bz = 0;
        repeat (10) begin
            @(negedge clk);
            bz += int'(busy);
        end
        chk("start during convert ignored", bz == 0, 64'(bz), 64'd0);

        // continuous: two frames back to back, mode dropped during the second
        load_frame(0, 2);
        continuous = 1;
        start_frame(16'd3);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_finished && n < 3000);
        chk("continuous frame 1 finished", frame_finished, 64'(frame_finished), 64'd1);
        @(negedge clk);
        chk("erase after finish", pixel_erase && busy, 64'({pixel_erase, busy}), 64'b11);
        continuous = 0;
        wait_finish("continuous frame 2");
        @(negedge clk);
        chk("idle after continuous drop", !busy && !pixel_erase, 64'({pixel_erase, busy}), 64'd0);
        ff_exp += 2;

        // reset mid-ramp aborts the frame
        load_frame(0, 1);
        start_frame(16'd10);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (digital_ramp != PB'(100) && n < 1000);
        chk("ramp reached 100", digital_ramp == PB'(100), 64'(digital_ramp), 64'd100);
        #1 rst = 1;
        #1 chk("async reset clears outputs", all_outs() == 0, all_outs(), 64'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst = 0;
        load_frame(0, 1);
        start_frame(16'($urandom_range(0, 15)));
        wait_finish("post reset frame");
        ff_exp++;

        repeat (5) @(negedge clk);
        chk("frame_finished count", ff_seen == ff_exp, 64'(ff_seen), 64'(ff_exp));
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
